// File: rtl/bwn_stage_scheduler_pkg.sv
// Shared definitions for the BWN stage scheduler: engine widths, the STATE code
// that enables engine ROM addressing, FSM encodings and small decode helpers.
package bwn_stage_scheduler_pkg;

    localparam int BL  = 154;
    localparam int SW  = 6;
    localparam int STW = 5;

    localparam logic [STW-1:0] LSTATE = 5'd3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_GATE  = 4'd2,
        ST_START = 4'd3,
        ST_RUN   = 4'd4,
        ST_CAPT  = 4'd5,
        ST_DRAIN = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } sched_state_e;

    // A stage is "active" (ROM address held, engine STATE asserted) from LOAD through CAPT.
    function automatic logic stage_active(input sched_state_e s);
        logic act;
        case (s)
            ST_LOAD, ST_GATE, ST_START, ST_RUN, ST_CAPT: act = 1'b1;
            default:                                     act = 1'b0;
        endcase
        return act;
    endfunction

    function automatic logic layer_busy(input sched_state_e s);
        return stage_active(s) || (s == ST_DRAIN);
    endfunction

    // Start credit: queue occupancy after this cycle's pop must leave room for one more result.
    function automatic logic start_credit_ok(input logic [1:0] count, input logic pop);
        logic [1:0] eff;
        eff = count - {1'b0, pop};
        return (eff <= 2'd1);
    endfunction

endpackage

// File: rtl/bwn_stage_scheduler_if.sv
// Engine-side and downstream-side signals of the stage scheduler.
// master = scheduler, slave = engine plus result packer.
interface bwn_stage_scheduler_if;
    import bwn_stage_scheduler_pkg::*;

    logic            start_s;
    logic [STW-1:0]  stage_state_s;
    logic [SW-1:0]   cnt_stage_s;
    logic            eng_end_s;
    logic [BL-1:0]   eng_data_s;
    logic            valid_s;
    logic            ready_s;
    logic [BL-1:0]   data_s;
    logic [SW-1:0]   tag_s;

    modport master (
        output start_s, stage_state_s, cnt_stage_s, valid_s, data_s, tag_s,
        input  eng_end_s, eng_data_s, ready_s
    );

    modport slave (
        input  start_s, stage_state_s, cnt_stage_s, valid_s, data_s, tag_s,
        output eng_end_s, eng_data_s, ready_s
    );

endinterface

// File: rtl/bwn_stage_scheduler_result_fifo.sv
// Two-entry first-word-fall-through result queue with a sync clear and an
// occupancy output; a push is accepted while full when the head pops in the same cycle.
module bwn_result_fifo #(
    parameter int W = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic          valid,
    output logic [W-1:0]  rdata,
    output logic [1:0]    count
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         pop_ok_s;
    logic         push_ok_s;

    // Qualify handshakes against the current occupancy.
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge iCLK) begin
        if (iRST || clr) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) wr_ptr_r <= ~wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= ~rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign valid = (count_r != 2'd0);
    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/bwn_stage_scheduler.sv
// Walks the BWN engine through every output stage of a layer: address ROM, wait latency,
// start engine, capture tagged result into a credit-guarded 2-entry queue, then drain.
module bwn_stage_scheduler
    import bwn_stage_scheduler_pkg::*;
#(
    parameter int NSTG    = 64,
    parameter int ROM_LAT = 2,
    parameter int TMO     = 1023,
    parameter int TW      = 10
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iGO,
    output logic                   oBUSY,
    output logic                   oDONE,
    output logic                   oERR,
    bwn_stage_scheduler_if.master  bus
);

    localparam int LW = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

    localparam logic [LW-1:0] LAT_LAST   = LW'(ROM_LAT - 1);
    localparam logic [LW-1:0] LAT_ONE    = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] STAGE_LAST = SW'(NSTG - 1);
    localparam logic [SW-1:0] STAGE_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] WD_LIMIT   = TW'(TMO);
    localparam logic [TW-1:0] WD_ONE     = {{(TW-1){1'b0}}, 1'b1};

    sched_state_e     state_r;
    sched_state_e     next_state_s;
    logic [SW-1:0]    stage_r;
    logic [LW-1:0]    lat_cnt_r;
    logic [TW-1:0]    wdog_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             start_r;
    logic [STW-1:0]   stage_state_r;

    logic             go_accept_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_clr_s;
    logic             fifo_valid_s;
    logic [1:0]       fifo_count_s;
    logic [BL+SW-1:0] fifo_dout_s;

    // Handshake qualifiers; the result is pushed on iEND so it is visible the cycle after.
    always_comb begin
        go_accept_s = (state_r == ST_IDLE) && iGO;
        fifo_pop_s  = fifo_valid_s && bus.ready_s;
        fifo_push_s = (state_r == ST_RUN) && bus.eng_end_s;
        fifo_clr_s  = (next_state_s == ST_ERR);
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iGO) next_state_s = ST_LOAD;
                else     next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (lat_cnt_r == LAT_LAST) next_state_s = ST_GATE;
                else                       next_state_s = ST_LOAD;
            end
            ST_GATE: begin
                if (start_credit_ok(fifo_count_s, fifo_pop_s)) next_state_s = ST_START;
                else                                           next_state_s = ST_GATE;
            end
            ST_START: next_state_s = ST_RUN;
            ST_RUN: begin
                if (bus.eng_end_s)          next_state_s = ST_CAPT;
                else if (wdog_r == WD_LIMIT) next_state_s = ST_ERR;
                else                         next_state_s = ST_RUN;
            end
            ST_CAPT: begin
                if (stage_r == STAGE_LAST) next_state_s = ST_DRAIN;
                else                       next_state_s = ST_LOAD;
            end
            ST_DRAIN: begin
                if (fifo_count_s == 2'd0) next_state_s = ST_DONE;
                else                      next_state_s = ST_DRAIN;
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Stage index, ROM latency counter and RUN watchdog.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stage_r   <= {SW{1'b0}};
            lat_cnt_r <= {LW{1'b0}};
            wdog_r    <= {TW{1'b0}};
        end else begin
            if (go_accept_s)
                stage_r <= {SW{1'b0}};
            else if ((state_r == ST_CAPT) && (next_state_s == ST_LOAD))
                stage_r <= stage_r + STAGE_ONE;
            else if ((state_r == ST_DONE) || (state_r == ST_ERR))
                stage_r <= {SW{1'b0}};

            lat_cnt_r <= (state_r == ST_LOAD) ? (lat_cnt_r + LAT_ONE) : {LW{1'b0}};

            if (next_state_s == ST_START)
                wdog_r <= {TW{1'b0}};
            else if ((state_r == ST_RUN) && (wdog_r != {TW{1'b1}}))
                wdog_r <= wdog_r + WD_ONE;
        end
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            start_r       <= 1'b0;
            stage_state_r <= {STW{1'b0}};
        end else begin
            busy_r        <= layer_busy(next_state_s);
            done_r        <= (next_state_s == ST_DONE);
            start_r       <= (next_state_s == ST_START);
            stage_state_r <= stage_active(next_state_s) ? LSTATE : {STW{1'b0}};
            if (next_state_s == ST_ERR) err_r <= 1'b1;
            else if (go_accept_s)       err_r <= 1'b0;
        end
    end

    bwn_result_fifo #(
        .W (BL + SW)
    ) u_fifo (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .clr   (fifo_clr_s),
        .push  (fifo_push_s),
        .wdata ({stage_r, bus.eng_data_s}),
        .pop   (fifo_pop_s),
        .valid (fifo_valid_s),
        .rdata (fifo_dout_s),
        .count (fifo_count_s)
    );

    assign oBUSY             = busy_r;
    assign oDONE             = done_r;
    assign oERR              = err_r;
    assign bus.start_s       = start_r;
    assign bus.stage_state_s = stage_state_r;
    assign bus.cnt_stage_s   = stage_r;
    assign bus.valid_s       = fifo_valid_s;
    assign bus.data_s        = fifo_dout_s[BL-1:0];
    assign bus.tag_s         = fifo_dout_s[BL+SW-1:BL];

endmodule
